stage_pf: RTL and testbench
===========================

STAGE_PF -- requirements
Module: stage_pf

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C000000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port allowout  input  1  downstream fetch stage can accept this cycle.
REQ-005 SHALL have port validout  output  1  output_pc is a deliverable fetch this cycle.
REQ-006 SHALL have port output_pc  output  32  PC of the fetch whose data is on inst_sram_rdata this cycle.
REQ-007 SHALL have port output_adef  output  1  output_pc is misaligned (pc[1:0] != 0).
REQ-008 SHALL have port br_taken  input  1  one-cycle redirect request from a later stage.
REQ-009 SHALL have port br_target  input  32  redirect address, sampled when br_taken=1.
REQ-010 SHALL have port inst_sram_en  output  1  synchronous-read instruction SRAM enable.
REQ-011 SHALL have port inst_sram_addr  output  32  read address; data returns next cycle.
REQ-012 SHALL have port inst_sram_we  output  4  write strobes, constant 0.

Function
REQ-013 SHALL hold state: started (1b), valid (1b), pc (32b); pc = address issued to SRAM on the previous edge.
REQ-014 SHALL drive validout = started & valid & ~br_taken (combinational kill of wrong-path fetch).
REQ-015 SHALL drive output_pc = pc and output_adef = valid & (pc[1:0] != 0).
REQ-016 SHALL define advance = validout & allowout; nextpc = pc + 4 (mod 2^32, wraps silently).
REQ-017 SHALL select address, priority high to low: ~started -> RESET_PC; br_taken -> br_target; advance -> nextpc; else -> pc (reissue so SRAM data stays stable during stall).
REQ-018 SHALL load pc <= selected address and valid <= 1 on every edge while rst_n=1; started <= 1 on first edge after reset release.
REQ-019 SHALL drive inst_sram_en = 1 whenever rst_n=1, except 0 when selected address[1:0] != 0.
REQ-020 SHALL, on a misaligned address, still load pc and deliver it with output_adef=1 (no SRAM access); data on rdata for that fetch is don't-care.
REQ-021 SHALL give br_taken priority over allowout: br_taken with allowout=1 delivers nothing that cycle; target appears on output_pc next cycle.
REQ-022 SHALL accept br_taken on consecutive cycles; the last target wins.
REQ-023 SHALL accept br_taken in the first cycle after reset release but ignore it (RESET_PC wins).
REQ-024 SHALL give fetch latency of 1 cycle from address issue to validout, with throughput of one PC per cycle when allowout=1 continuously.

Reset
REQ-025 SHALL, while rst_n=0, force started=0, valid=0, pc=RESET_PC-4, validout=0, inst_sram_en=0, inst_sram_we=0.
REQ-026 SHALL abort any in-flight fetch when rst_n asserts mid-operation; no stale PC is delivered after release.

Structure
REQ-027 SHALL take RESET_PC default and the 32-bit instruction width constant from the shared CPU package.
REQ-028 SHALL contain one natural sub-module, npc_sel, implementing the REQ-017 address mux; all state stays in stage_pf.

Verification
REQ-029 SHALL check reset release with allowout=1: cycle 0 addr=1C000000 en=1 validout=0; cycle 1 validout=1 pc=1C000000 addr=1C000004.
REQ-030 SHALL check stall: allowout=0 for 3 cycles at pc=1C000008 -> addr held 1C000008, output_pc stable, validout=1; release -> addr=1C00000C.
REQ-031 SHALL check redirect: br_taken=1, br_target=1C000100 at pc=1C000010 -> validout=0 that cycle, addr=1C000100; next cycle output_pc=1C000100.
REQ-032 SHALL check redirect during stall: allowout=0, br_taken=1 target=1C000200 -> next cycle output_pc=1C000200, validout=1.
REQ-033 SHALL check misaligned target 1C000302 -> en=0 that cycle; next cycle output_pc=1C000302, output_adef=1.
REQ-034 SHALL check async reset mid-stream at pc=1C000040 -> validout=0 and en=0 immediately, without a clock edge; restart from 1C000000.

Source files
------------

// File: rtl/stage_pf_pkg.sv
// Shared CPU constants and helpers used by the pre-fetch stage.
package stage_pf_pkg;

  // Instruction and address width of the core.
  localparam int unsigned INST_W = 32;

  // First fetch address after reset.
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  // Sequential fetch stride in bytes.
  localparam logic [INST_W-1:0] PC_STEP = 32'd4;

  // Source of the next fetch address, highest priority first.
  typedef enum logic [1:0] {
    SelReset,
    SelBranch,
    SelNext,
    SelHold
  } npc_src_e;

  // True when an address is not word aligned.
  function automatic logic is_misaligned(input logic [INST_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Next fetch address selection: reset vector, redirect, sequential or reissue.
module npc_sel
  import stage_pf_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              started,
  input  logic              br_taken,
  input  logic              advance,
  input  logic [INST_W-1:0] br_target,
  input  logic [INST_W-1:0] pc,
  output logic [INST_W-1:0] npc
);

  npc_src_e src;

  // Priority decode of the address source.
  always_comb begin
    src = SelHold;
    if (!started) begin
      src = SelReset;
    end else if (br_taken) begin
      src = SelBranch;
    end else if (advance) begin
      src = SelNext;
    end
  end

  // Address mux; the hold case reissues pc so SRAM data stays stable while stalled.
  always_comb begin
    npc = pc;
    unique case (src)
      SelReset:  npc = RESET_PC;
      SelBranch: npc = br_target;
      SelNext:   npc = pc + PC_STEP;
      SelHold:   npc = pc;
    endcase
  end

endmodule

// File: rtl/stage_pf.sv
// Pre-fetch stage: issues instruction SRAM addresses and presents the fetched PC.
module stage_pf
  import stage_pf_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              allowout,
  output logic              validout,
  output logic [INST_W-1:0] output_pc,
  output logic              output_adef,
  input  logic              br_taken,
  input  logic [INST_W-1:0] br_target,
  output logic              inst_sram_en,
  output logic [INST_W-1:0] inst_sram_addr,
  output logic [3:0]        inst_sram_we
);

  logic              started_q;
  logic              valid_q;
  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] npc;
  logic              advance;

  // Wrong-path fetch is killed combinationally by a redirect in the same cycle.
  assign advance = validout & allowout;

  npc_sel #(
    .RESET_PC (RESET_PC)
  ) u_npc_sel (
    .started   (started_q),
    .br_taken  (br_taken),
    .advance   (advance),
    .br_target (br_target),
    .pc        (pc_q),
    .npc       (npc)
  );

  // pc tracks the address issued on the previous edge; reset value makes the
  // pre-start state look like the slot just before the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC - PC_STEP;
    end else begin
      started_q <= 1'b1;
      valid_q   <= 1'b1;
      pc_q      <= npc;
    end
  end

  // Output decode; SRAM is idle in reset and for misaligned addresses.
  always_comb begin
    validout       = started_q & valid_q & ~br_taken;
    output_pc      = pc_q;
    output_adef    = valid_q & is_misaligned(pc_q);
    inst_sram_addr = npc;
    inst_sram_en   = rst_n & ~is_misaligned(npc);
    inst_sram_we   = 4'b0000;
  end

endmodule

// File: tb/tb_stage_pf.sv
// Self-checking bench for stage_pf: reference model plus directed scenarios.
module tb_stage_pf;

  localparam logic [31:0] RPC = 32'h1C00_0000;

  logic        clk;
  logic        rst_n;
  logic        allowout;
  logic        validout;
  logic [31:0] output_pc;
  logic        output_adef;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_we;

  int n_cmp = 0;
  int n_bad = 0;

  stage_pf #(
    .RESET_PC (RPC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .allowout       (allowout),
    .validout       (validout),
    .output_pc      (output_pc),
    .output_adef    (output_adef),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_we   (inst_sram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which fetch is "in hand" (the one issued last edge).
  logic        m_started;
  logic        m_have;
  logic [31:0] m_pc;

  function automatic logic [31:0] model_addr();
    logic deliver;
    deliver = m_started && m_have && !br_taken;
    if (!m_started)            return RPC;
    if (br_taken)              return br_target;
    if (deliver && allowout)   return m_pc + 32'd4;
    return m_pc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_have    <= 1'b0;
      m_pc      <= RPC - 32'd4;
    end else begin
      m_pc      <= model_addr();
      m_started <= 1'b1;
      m_have    <= 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] a;
    a = model_addr();
    check("m_validout", {31'b0, validout}, {31'b0, m_started && m_have && !br_taken});
    check("m_output_pc", output_pc, m_pc);
    check("m_adef", {31'b0, output_adef}, {31'b0, m_have && (m_pc[1:0] != 2'b00)});
    check("m_addr", inst_sram_addr, a);
    check("m_en", {31'b0, inst_sram_en}, {31'b0, rst_n && (a[1:0] == 2'b00)});
    check("m_we", {28'b0, inst_sram_we}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    allowout  = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'h0;

    // Held in reset.
    step();
    step();
    at_neg();
    check("rst_validout", {31'b0, validout}, 32'd0);
    check("rst_en", {31'b0, inst_sram_en}, 32'd0);
    check("rst_we", {28'b0, inst_sram_we}, 32'd0);
    check("rst_pc", output_pc, 32'h1BFF_FFFC);

    // Release: cycle 0 then cycle 1.
    step();
    rst_n = 1'b1;
    at_neg();
    check("c0_addr", inst_sram_addr, 32'h1C00_0000);
    check("c0_en", {31'b0, inst_sram_en}, 32'd1);
    check("c0_validout", {31'b0, validout}, 32'd0);
    step();
    at_neg();
    check("c1_validout", {31'b0, validout}, 32'd1);
    check("c1_pc", output_pc, 32'h1C00_0000);
    check("c1_addr", inst_sram_addr, 32'h1C00_0004);

    // Stall three cycles at 1C000008.
    step();
    step();
    allowout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("stall_addr", inst_sram_addr, 32'h1C00_0008);
      check("stall_pc", output_pc, 32'h1C00_0008);
      check("stall_validout", {31'b0, validout}, 32'd1);
      step();
    end
    allowout = 1'b1;
    at_neg();
    check("unstall_addr", inst_sram_addr, 32'h1C00_000C);

    // Redirect at 1C000010.
    step();
    step();
    br_taken  = 1'b1;
    br_target = 32'h1C00_0100;
    at_neg();
    check("br_pc", output_pc, 32'h1C00_0010);
    check("br_validout", {31'b0, validout}, 32'd0);
    check("br_addr", inst_sram_addr, 32'h1C00_0100);
    step();
    br_taken = 1'b0;
    at_neg();
    check("br_tgt_pc", output_pc, 32'h1C00_0100);
    check("br_tgt_validout", {31'b0, validout}, 32'd1);

    // Redirect during stall.
    allowout  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1C00_0200;
    at_neg();
    check("sbr_addr", inst_sram_addr, 32'h1C00_0200);
    step();
    br_taken = 1'b0;
    at_neg();
    check("sbr_pc", output_pc, 32'h1C00_0200);
    check("sbr_validout", {31'b0, validout}, 32'd1);

    // Misaligned target.
    allowout  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h1C00_0302;
    at_neg();
    check("mis_en", {31'b0, inst_sram_en}, 32'd0);
    step();
    br_taken = 1'b0;
    at_neg();
    check("mis_pc", output_pc, 32'h1C00_0302);
    check("mis_adef", {31'b0, output_adef}, 32'd1);

    // Back-to-back redirects: last target wins.
    br_taken  = 1'b1;
    br_target = 32'h1C00_0400;
    step();
    br_target = 32'h1C00_0040;
    at_neg();
    check("bb_validout", {31'b0, validout}, 32'd0);
    step();
    br_taken = 1'b0;
    at_neg();
    check("bb_pc", output_pc, 32'h1C00_0040);
    check("bb_adef", {31'b0, output_adef}, 32'd0);

    // Asynchronous reset away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_validout", {31'b0, validout}, 32'd0);
    check("arst_en", {31'b0, inst_sram_en}, 32'd0);
    check("arst_pc", output_pc, 32'h1BFF_FFFC);
    step();
    step();

    // Restart with a redirect in the first cycle: reset vector must win.
    rst_n     = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h1C00_0500;
    at_neg();
    check("rs_addr", inst_sram_addr, 32'h1C00_0000);
    check("rs_en", {31'b0, inst_sram_en}, 32'd1);
    check("rs_validout", {31'b0, validout}, 32'd0);
    step();
    br_taken = 1'b0;
    at_neg();
    check("rs_pc", output_pc, 32'h1C00_0000);
    check("rs_validout1", {31'b0, validout}, 32'd1);

    // PC wrap at the top of the address space.
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    at_neg();
    check("wrap_pc", output_pc, 32'hFFFF_FFFC);
    check("wrap_addr", inst_sram_addr, 32'h0000_0000);
    step();
    at_neg();
    check("wrap_pc1", output_pc, 32'h0000_0000);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
